// File: rtl/valve_sequencer_if.sv
// Irrigation valve bundle. The controller side drives the zone requests,
// the status code and the fault acknowledge. The sequencer side returns
// the valve drives, the pump enable, the alarm and the pending flag.
interface valve_sequencer_if;
   logic [1:0] R1;       // zone-1 request, one bit per valve
   logic [1:0] R2;       // zone-2 request, one bit per valve
   logic [1:0] E;        // controller status, 2'b01 = normal
   logic       ack;      // operator fault acknowledge
   logic [3:0] V;        // valve drives {R2[1],R2[0],R1[1],R1[0]}
   logic       pump;     // pump enable
   logic       alarm;    // latched fault indicator
   logic       pending;  // some requested valve is still closed

   modport master (
      output R1, R2, E, ack,
      input  V, pump, alarm, pending
   );

   modport slave (
      input  R1, R2, E, ack,
      output V, pump, alarm, pending
   );
endinterface

// File: rtl/valve_sequencer.sv
// Valve sequencer. Opens the requested irrigation valves one at a time,
// leaving at least STAGGER cycles between successive openings. Once a valve
// opens it stays open for at least MIN_ON cycles. A controller fault shuts
// everything off and latches the alarm. The alarm is released only when the
// operator acknowledges it and the controller reports normal status again.
module valve_sequencer #(
   parameter int unsigned STAGGER = 4,  // legal 1..255
   parameter int unsigned MIN_ON  = 8   // legal 1..255
) (
   input logic              clk,
   input logic              reset,
   valve_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [7:0] STAG_LOAD = 8'(STAGGER - 1);
   localparam logic [7:0] ON_MAX    = 8'(MIN_ON);

   state_t     state, state_nxt;
   logic [3:0] v, v_nxt;
   logic [7:0] on_cnt [4];
   logic [7:0] on_cnt_nxt [4];
   logic [7:0] stag_cnt, stag_cnt_nxt;
   logic       pump, pump_nxt;
   logic       alarm, alarm_nxt;

   logic [3:0] req;
   logic       fault;
   logic [3:0] waiting;
   logic       open_en;
   logic [1:0] open_idx;
   logic [2:0] pick;

   // Returns {found, index} of the lowest set bit of a 4-bit vector.
   function automatic logic [2:0] lowest(input logic [3:0] bits);
      logic [2:0] r;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (bits[i]) r = {1'b1, 2'(i)};
      end
      return r;
   endfunction

   assign req     = {bus.R2, bus.R1};
   assign fault   = (bus.E != 2'b01);
   assign waiting = req & ~v;

   // Valve output ports and the combinational pending flag.
   assign bus.V       = v;
   assign bus.pump    = pump;
   assign bus.alarm   = alarm;
   assign bus.pending = (state != FAULT) && (|waiting);

   // Next-state logic: valve openings and closings, counters, fault handling.
   // NOTE: every signal written here gets its default value first, so no path
   // can leave one unassigned and turn it into a latch.
   always_comb begin
      state_nxt    = state;
      v_nxt        = v;
      stag_cnt_nxt = stag_cnt;
      alarm_nxt    = alarm;
      for (int i = 0; i < 4; i++) on_cnt_nxt[i] = on_cnt[i];
      open_en  = 1'b0;
      open_idx = 2'd0;
      pick     = 3'b000;

      case (state)
         IDLE: begin
            v_nxt = 4'b0000;
            if (stag_cnt != 8'd0) stag_cnt_nxt = stag_cnt - 8'd1;
            if (fault) begin
               state_nxt    = FAULT;
               alarm_nxt    = 1'b1;
               stag_cnt_nxt = 8'd0;
               for (int i = 0; i < 4; i++) on_cnt_nxt[i] = 8'd0;
            end else if (req != 4'b0000) begin
               pick      = lowest(req);
               open_en   = 1'b1;
               open_idx  = pick[1:0];
               state_nxt = RUN;
            end
         end

         RUN: begin
            if (fault) begin
               // A fault overrides the minimum on-time and shuts every valve.
               state_nxt    = FAULT;
               v_nxt        = 4'b0000;
               alarm_nxt    = 1'b1;
               stag_cnt_nxt = 8'd0;
               for (int i = 0; i < 4; i++) on_cnt_nxt[i] = 8'd0;
            end else begin
               if (stag_cnt != 8'd0) stag_cnt_nxt = stag_cnt - 8'd1;
               // An open valve may close only after its minimum on-time, and
               // only if nobody asks for it any more. If its request comes
               // back before then, it simply keeps running on the same count.
               for (int i = 0; i < 4; i++) begin
                  if (v[i]) begin
                     if (!req[i] && (on_cnt[i] == ON_MAX)) begin
                        v_nxt[i]      = 1'b0;
                        on_cnt_nxt[i] = 8'd0;
                     end else if (on_cnt[i] != ON_MAX) begin
                        on_cnt_nxt[i] = on_cnt[i] + 8'd1;
                     end
                  end
               end
               // At most one new opening per edge, lowest waiting index first.
               if (stag_cnt == 8'd0) begin
                  pick     = lowest(waiting);
                  open_en  = pick[2];
                  open_idx = pick[1:0];
               end
               if (!open_en && (v_nxt == 4'b0000) && (req == 4'b0000)) begin
                  state_nxt = IDLE;
               end
            end
         end

         FAULT: begin
            v_nxt     = 4'b0000;
            alarm_nxt = 1'b1;
            if (bus.ack && !fault) begin
               state_nxt = IDLE;
               alarm_nxt = 1'b0;
            end
         end

         default: begin
            state_nxt    = IDLE;
            v_nxt        = 4'b0000;
            alarm_nxt    = 1'b0;
            stag_cnt_nxt = 8'd0;
            for (int i = 0; i < 4; i++) on_cnt_nxt[i] = 8'd0;
         end
      endcase

      // A newly opened valve starts its on-time count and restarts the stagger.
      if (open_en) begin
         v_nxt[open_idx]      = 1'b1;
         on_cnt_nxt[open_idx] = 8'd1;
         stag_cnt_nxt         = STAG_LOAD;
      end

      // The pump follows the valve drives on the same edge.
      pump_nxt = |v_nxt;
   end

   // State register. Reset forces everything to zero at once, even without a clock.
   // NOTE: sequential state uses non-blocking assignments, so every register
   // updates from values taken before the edge.
   // NOTE: the on-time counters are a small register array, not a RAM, so they
   // are reset together with the rest of the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         v        <= 4'b0000;
         stag_cnt <= 8'd0;
         pump     <= 1'b0;
         alarm    <= 1'b0;
         for (int i = 0; i < 4; i++) on_cnt[i] <= 8'd0;
      end else begin
         state    <= state_nxt;
         v        <= v_nxt;
         stag_cnt <= stag_cnt_nxt;
         pump     <= pump_nxt;
         alarm    <= alarm_nxt;
         for (int i = 0; i < 4; i++) on_cnt[i] <= on_cnt_nxt[i];
      end
   end

endmodule

// File: tb/tb_valve_sequencer.sv
// Testbench for valve_sequencer (STAGGER=4, MIN_ON=8). The expected
// {V, pump, alarm, pending} for each step is queued as the stimulus is
// driven. It is popped and compared once the DUT has updated.
module tb_valve_sequencer;

   logic clk;
   logic reset;

   valve_sequencer_if bus ();

   valve_sequencer #(
      .STAGGER(4),
      .MIN_ON (8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   typedef struct {
      string      tag;
      logic [6:0] val;  // {V, pump, alarm, pending}
   } exp_t;

   exp_t sb[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Queue one expected outcome.
   task automatic push(input string tag, input logic [3:0] v, input logic p,
                       input logic al, input logic pe);
      exp_t e;
      e.tag = tag;
      e.val = {v, p, al, pe};
      sb.push_back(e);
   endtask

   // Pop the oldest expectation and compare it with the DUT outputs.
   task automatic check();
      exp_t       e;
      logic [6:0] obs;
      obs = {bus.V, bus.pump, bus.alarm, bus.pending};
      tests_run++;
      if (sb.size() == 0) begin
         tests_failed++;
         $error("FAIL scoreboard_empty: observed=%b required=an expectation", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val)
         else begin
            tests_failed++;
            $error("FAIL %s: observed {V,pump,alarm,pending}=%b required=%b",
                   e.tag, obs, e.val);
         end
      end
   endtask

   // Drive the inputs, queue the expected result of the next edge, then
   // sample 1 time unit after that edge.
   task automatic step(input logic [1:0] r1, input logic [1:0] r2,
                       input logic [1:0] e, input logic a,
                       input logic [3:0] v, input logic p, input logic al,
                       input logic pe, input string tag);
      bus.R1  = r1;
      bus.R2  = r2;
      bus.E   = e;
      bus.ack = a;
      push(tag, v, p, al, pe);
      @(posedge clk);
      #1;
      check();
   endtask

   // Assert reset between edges and check that it acts at once. Then clear
   // the inputs and release reset on a falling edge.
   task automatic async_reset(input string tag, input logic pe);
      #2;
      reset = 1'b1;
      #1;
      push(tag, 4'b0000, 1'b0, 1'b0, pe);
      check();
      bus.R1  = 2'b00;
      bus.R2  = 2'b00;
      bus.E   = 2'b01;
      bus.ack = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] vexp;

      // Reset state.
      reset   = 1'b1;
      bus.R1  = 2'b00;
      bus.R2  = 2'b00;
      bus.E   = 2'b01;
      bus.ack = 1'b0;
      #3;
      push("reset_state", 4'b0000, 1'b0, 1'b0, 1'b0);
      check();
      @(negedge clk);
      reset = 1'b0;

      // Two valves in zone 1: the first opens on edge 1, the second on edge 5.
      step(2'b11, 2'b00, 2'b01, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, "a_open0_edge1");
      for (int i = 0; i < 3; i++)
         step(2'b11, 2'b00, 2'b01, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, "a_stagger_hold");
      step(2'b11, 2'b00, 2'b01, 1'b0, 4'b0011, 1'b1, 1'b0, 1'b0, "a_open1_edge5");
      // Reset in the middle of RUN clears the outputs before the next edge.
      async_reset("a_reset_mid_run", 1'b1);

      // Short request: the valve still runs its full minimum on-time.
      for (int i = 0; i < 2; i++)
         step(2'b01, 2'b00, 2'b01, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, "b_open_req");
      for (int i = 0; i < 6; i++)
         step(2'b00, 2'b00, 2'b01, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, "b_min_on_hold");
      step(2'b00, 2'b00, 2'b01, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, "b_close_edge9");
      step(2'b00, 2'b00, 2'b01, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, "b_idle_after");

      // Close and open on the same edge; the pump stays on.
      for (int i = 0; i < 8; i++)
         step(2'b01, 2'b00, 2'b01, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, "c_v0_open");
      step(2'b10, 2'b00, 2'b01, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, "c_swap_edge9");
      for (int i = 0; i < 7; i++)
         step(2'b00, 2'b00, 2'b01, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, "c_v1_min_on");
      step(2'b00, 2'b00, 2'b01, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, "c_v1_close");

      // All four requested: openings on edges 1, 5, 9 and 13, in index order.
      for (int g = 0; g < 4; g++) begin
         vexp = 4'((5'd1 << (g + 1)) - 5'd1);
         step(2'b11, 2'b11, 2'b01, 1'b0, vexp, 1'b1, 1'b0, (g < 3), "d_open_order");
         if (g < 3)
            for (int i = 0; i < 3; i++)
               step(2'b11, 2'b11, 2'b01, 1'b0, vexp, 1'b1, 1'b0, 1'b1, "d_stagger_hold");
      end
      // A fault overrides the minimum on-time of freshly opened valves.
      step(2'b11, 2'b11, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, "d_fault_overrides");
      step(2'b00, 2'b00, 2'b01, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, "d_ack_clears");

      // Fault out of V=0101, ack while the fault persists, then a clean ack.
      for (int i = 0; i < 4; i++)
         step(2'b01, 2'b01, 2'b01, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, "e_open0");
      step(2'b01, 2'b01, 2'b01, 1'b0, 4'b0101, 1'b1, 1'b0, 1'b0, "e_open2");
      step(2'b01, 2'b01, 2'b00, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, "e_fault_edge1");
      step(2'b01, 2'b01, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, "e_ack_fault_00");
      step(2'b01, 2'b01, 2'b10, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, "e_ack_fault_10");
      step(2'b01, 2'b01, 2'b01, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, "e_ack_exit_idle");
      step(2'b01, 2'b01, 2'b01, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, "e_ack_in_idle");
      step(2'b01, 2'b01, 2'b01, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b1, "e_ack_in_run");
      async_reset("e_reset_in_run", 1'b1);

      // A fault seen in IDLE wins over pending requests. Reset then clears
      // the alarm at once.
      step(2'b01, 2'b01, 2'b11, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, "f_idle_fault");
      step(2'b01, 2'b01, 2'b11, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, "f_fault_hold");
      async_reset("f_reset_in_fault", 1'b1);
      step(2'b00, 2'b00, 2'b01, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, "f_idle_after_reset");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/valve_sequencer.md
VALVE_SEQUENCER -- requirements
Module: valve_sequencer

Interface
REQ-001 Parameter STAGGER, default 4, minimum cycles between successive valve openings, legal 1..255.
REQ-002 Parameter MIN_ON, default 8, minimum cycles a valve stays open once opened, legal 1..255.
REQ-003 Port clk  input  1  system clock, all state updates on rising edge.
REQ-004 Port reset  input  1  reset, asynchronous, active-high.
REQ-005 Port R1  input  2  zone-1 water request from irrigation controller, bit=1 means water for that valve.
REQ-006 Port R2  input  2  zone-2 water request, same encoding.
REQ-007 Port E  input  2  controller status, 2'b01 normal, any other value fault.
REQ-008 Port ack  input  1  operator fault acknowledge, level-sampled.
REQ-009 Port V  output  4  valve drives, V[0]=R1[0], V[1]=R1[1], V[2]=R2[0], V[3]=R2[1].
REQ-010 Port pump  output  1  pump enable, registered.
REQ-011 Port alarm  output  1  latched fault indicator, registered.
REQ-012 Port pending  output  1  combinational, high when any requested valve is not yet open.

Function
REQ-013 Request vector req SHALL be {R2,R1}; fault SHALL be (E != 2'b01); all inputs are sampled on the rising edge.
REQ-014 FSM SHALL have states IDLE, RUN, FAULT, encoded in 2 bits.
REQ-015 IDLE: V=0, pump=0; on fault go to FAULT; else if req!=0 go to RUN and open the lowest-index requested valve on the same edge.
REQ-016 Opening a valve SHALL load its on-counter with 1 and load the stagger counter with STAGGER-1.
REQ-017 Stagger counter SHALL decrement by 1 per cycle, saturating at 0; in RUN a new valve opens only when the counter is 0, lowest pending index first, with at most one opening per edge.
REQ-018 Each open valve's 8-bit on-counter SHALL increment per cycle, saturating at MIN_ON.
REQ-019 An open valve SHALL close on an edge where its req bit is 0 and its on-counter equals MIN_ON; otherwise it stays open.
REQ-020 A valve whose req bit re-asserts before closing SHALL stay open without reloading its counter.
REQ-021 One valve closing and another opening on the same edge SHALL both take effect.
REQ-022 RUN SHALL return to IDLE on the edge where V and req are both 0 after the update.
REQ-023 pump SHALL equal the OR of the next-state V, so it changes on the same edge as V.
REQ-024 Fault in IDLE or RUN SHALL, on the next edge, force V=0 and pump=0 (overriding MIN_ON), set alarm=1, clear all counters, and enter FAULT.
REQ-025 FAULT SHALL hold V=0, pump=0 and alarm=1; it SHALL exit to IDLE with alarm=0 only on an edge where ack=1 and E==2'b01.
REQ-026 ack with a persisting fault SHALL be ignored, and ack outside FAULT SHALL have no effect.
REQ-027 pending SHALL equal |(req & ~V) while the state is not FAULT, and 0 in FAULT.

Reset
REQ-028 reset SHALL immediately force state=IDLE, V=4'b0000, pump=0, alarm=0, and all counters to 0, regardless of clock or current state.
REQ-029 On the first edge after reset deasserts, normal operation SHALL start from IDLE.

Verification (STAGGER=4, MIN_ON=8; edge k = k-th rising edge after stimulus applied)
REQ-030 Assert reset mid-RUN with V=4'b0011 -> V=0, pump=0, alarm=0 immediately, before the next edge.
REQ-031 From IDLE, R1=2'b11, R2=2'b00, E=2'b01 -> V=4'b0001 and pump=1 at edge 1, V=4'b0011 at edge 5.
REQ-032 From IDLE, R1=2'b01 held 2 cycles then 2'b00 -> V[0] high for exactly 8 cycles, closes at edge 9, state IDLE and pump=0 at edge 9.
REQ-033 From IDLE, R1=R2=2'b11 held -> valves open at edges 1, 5, 9, 13 in index order 0,1,2,3; pending=0 after edge 13.
REQ-034 In RUN with V=4'b0101, E=2'b00 -> V=0, pump=0, alarm=1 at edge 1; ack=1 with E=2'b00 -> remain in FAULT; ack=1 with E=2'b01 -> IDLE, alarm=0 at the next edge.
REQ-035 At V[0] close edge, R1=2'b10 with stagger counter 0 -> V goes 4'b0001 to 4'b0010 on the same edge, pump stays 1.
